// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall/bubble, branch flush, memory-busy stall.
// Optional feature: define HAZARD_STATS_EN to build the saturating load-use
// stall-cycle counter on StallCycles; otherwise StallCycles is tied to zero.
//
// state | meaning
// IDLE  | no load-use sequence in progress
// LU2   | second bubble of a load-use sequence is due
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  DRs,
  input  logic [2:0]  DRt,
  input  logic        DUsesRs,
  input  logic        DUsesRt,
  input  logic [2:0]  XRd,
  input  logic        XMemRead,
  input  logic        XRegWrite,
  input  logic        BranchTaken,
  input  logic        MemBusy,
  output logic        Stall,
  output logic        Bubble,
  output logic        Flush,
  output logic [15:0] StallCycles
);

  typedef enum logic {IDLE, LU2} state_t;

  state_t state, nextState;
  logic   loadUse;

  // Load in execute whose destination is read by the decode instruction.
  assign loadUse = XMemRead & XRegWrite &
                   ((DUsesRs & (DRs == XRd)) | (DUsesRt & (DRt == XRd)));

  // State register; reset drops any pending second bubble immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next state and outputs, priority MemBusy > BranchTaken > load-use.
  always_comb begin
    Stall     = 1'b0;
    Bubble    = 1'b0;
    Flush     = 1'b0;
    nextState = IDLE;
    if (rst) begin
      nextState = IDLE;
    end else if (MemBusy) begin
      Stall     = 1'b1;
      nextState = state;
    end else if (BranchTaken) begin
      Flush  = 1'b1;
      Bubble = 1'b1;
    end else if (state == LU2) begin
      Stall  = 1'b1;
      Bubble = 1'b1;
    end else if (loadUse) begin
      Stall     = 1'b1;
      Bubble    = 1'b1;
      nextState = LU2;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCnt;

  // Count load-use bubble cycles (Stall and Bubble together), saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stallCnt <= 16'h0000;
    else if (Stall && Bubble && (stallCnt != 16'hFFFF))
      stallCnt <= stallCnt + 16'h0001;
  end

  assign StallCycles = stallCnt;
`else
  assign StallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; counter expectations follow HAZARD_STATS_EN.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  DRs, DRt, XRd;
  logic        DUsesRs, DUsesRt, XMemRead, XRegWrite, BranchTaken, MemBusy;
  logic        Stall, Bubble, Flush;
  logic [15:0] StallCycles;

  int errors = 0;
  int checks = 0;

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .DRs(DRs), .DRt(DRt), .DUsesRs(DUsesRs), .DUsesRt(DUsesRt),
    .XRd(XRd), .XMemRead(XMemRead), .XRegWrite(XRegWrite),
    .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .Stall(Stall), .Bubble(Bubble), .Flush(Flush),
    .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // expected {Stall,Bubble,Flush}
  task automatic chkOut(input string tag, input logic [2:0] exp);
    chk(tag, {13'b0, Stall, Bubble, Flush}, {13'b0, exp});
  endtask

  function automatic logic [15:0] cntExp(input logic [15:0] n);
`ifdef HAZARD_STATS_EN
    return n;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setLu(input logic [2:0] rd, input logic [2:0] rs, input logic usesRs,
                       input logic [2:0] rt, input logic usesRt);
    XMemRead = 1'b1; XRegWrite = 1'b1; XRd = rd;
    DRs = rs; DUsesRs = usesRs; DRt = rt; DUsesRt = usesRt;
  endtask

  initial begin
    rst = 1'b1;
    BranchTaken = 1'b0; MemBusy = 1'b0;
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    #12;
    chkOut("reset_outputs", 3'b000);
    chk("reset_count", StallCycles, 16'h0000);
    XMemRead = 1'b0;
    #1 rst = 1'b0;

    // basic load-use on Rs: two bubbles
    step();
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    #2 chkOut("lu_rs_first", 3'b110);
    step(); XMemRead = 1'b0;
    #2 chkOut("lu_rs_second", 3'b110);
    step();
    #2 chkOut("lu_rs_done", 3'b000);
    chk("lu_rs_count", StallCycles, cntExp(16'd2));

    // registers match but neither is used
    setLu(3'd3, 3'd3, 1'b0, 3'd3, 1'b0);
    #1 chkOut("no_uses", 3'b000);
    step();
    #2 chkOut("no_uses_next", 3'b000);

    // load-use on Rt
    setLu(3'd3, 3'd0, 1'b0, 3'd3, 1'b1);
    #1 chkOut("lu_rt_first", 3'b110);
    step(); XMemRead = 1'b0;
    #2 chkOut("lu_rt_second", 3'b110);
    step();
    #2 chkOut("lu_rt_done", 3'b000);

    // load without register write is no hazard
    setLu(3'd3, 3'd0, 1'b0, 3'd3, 1'b1);
    XRegWrite = 1'b0;
    #1 chkOut("no_regwrite", 3'b000);
    step();
    #2 chkOut("no_regwrite_next", 3'b000);
    chk("count_after_rt", StallCycles, cntExp(16'd4));

    // back-to-back load-use on register 0, no dead cycle
    setLu(3'd0, 3'd0, 1'b1, 3'd5, 1'b0);
    #1 chkOut("b2b_1", 3'b110);
    step();
    #2 chkOut("b2b_2", 3'b110);
    step();
    #2 chkOut("b2b_3_restart", 3'b110);
    step(); XMemRead = 1'b0;
    #2 chkOut("b2b_4", 3'b110);
    step();
    #2 chkOut("b2b_done", 3'b000);
    chk("b2b_count", StallCycles, cntExp(16'd8));

    // memory busy during LU2 holds state and counter
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    #1 chkOut("mb_lu", 3'b110);
    step(); XMemRead = 1'b0; MemBusy = 1'b1;
    #2 chkOut("mb_busy1", 3'b100);
    step();
    #2 chkOut("mb_busy2", 3'b100);
    chk("mb_count_hold", StallCycles, cntExp(16'd9));
    step();
    #2 chkOut("mb_busy3", 3'b100);
    step(); MemBusy = 1'b0;
    #2 chkOut("mb_lu2", 3'b110);
    step();
    #2 chkOut("mb_done", 3'b000);
    chk("mb_count", StallCycles, cntExp(16'd10));

    // branch cancels pending LU2
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    #1 chkOut("br_lu", 3'b110);
    step(); XMemRead = 1'b0; BranchTaken = 1'b1;
    #2 chkOut("br_flush", 3'b011);
    step(); BranchTaken = 1'b0;
    #2 chkOut("br_after", 3'b000);

    // branch beats a fresh load-use and does not enter LU2
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    BranchTaken = 1'b1;
    #1 chkOut("br_over_lu", 3'b011);
    step(); XMemRead = 1'b0; BranchTaken = 1'b0;
    #2 chkOut("br_over_lu_after", 3'b000);
    chk("br_count", StallCycles, cntExp(16'd11));

    // async reset in LU2 drops the second bubble
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    #1 chkOut("rst_lu", 3'b110);
    step(); XMemRead = 1'b0;
    #2 chkOut("rst_in_lu2", 3'b110);
    rst = 1'b1;
    #1 chkOut("rst_immediate", 3'b000);
    chk("rst_count_clear", StallCycles, 16'h0000);
    #1 rst = 1'b0;
    step();
    #2 chkOut("rst_resume_idle", 3'b000);
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    #1 chkOut("rst_fresh1", 3'b110);
    step(); XMemRead = 1'b0;
    #2 chkOut("rst_fresh2", 3'b110);
    step();
    #2 chkOut("rst_fresh_done", 3'b000);
    chk("rst_fresh_count", StallCycles, cntExp(16'd2));

`ifdef HAZARD_STATS_EN
    // continuous load-use: every cycle is a bubble cycle
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    repeat (65532) step();
    chk("sat_preload", StallCycles, 16'hFFFE);
    repeat (3) step();
    chk("sat_hold", StallCycles, 16'hFFFF);
    XMemRead = 1'b0;
`else
    setLu(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    repeat (5) step();
    chk("stats_off_zero", StallCycles, 16'h0000);
    XMemRead = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
